// File: rtl/wadd_pkg.sv
// Shared types and constants for the byte-serial wide adder sequencer.
package wadd_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } wadd_state_t;

endpackage : wadd_pkg

// File: rtl/wide_add_sequencer.sv
// Feeds an external registered 8-bit adder one byte slice at a time (LSB first),
// chaining carries, and assembles the returned bytes into a wide result.
module wide_add_sequencer
   import wadd_pkg::*;
#(
   parameter int unsigned NBYTES  = 4,
   parameter int unsigned ADD_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [BYTE_W*NBYTES-1:0] in_a,
   input  logic [BYTE_W*NBYTES-1:0] in_b,
   input  logic                     in_cin,
   output logic [BYTE_W-1:0]        add_a,
   output logic [BYTE_W-1:0]        add_b,
   output logic                     add_cin,
   input  logic [BYTE_W-1:0]        add_sum,
   input  logic                     add_cout,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [BYTE_W*NBYTES-1:0] out_sum,
   output logic                     out_cout,
   output logic                     busy
);

   localparam int unsigned W     = BYTE_W * NBYTES;
   localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int unsigned CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

   wadd_state_t         r_state;
   logic [IDX_W-1:0]    r_idx;
   logic [CNT_W-1:0]    r_cnt;
   logic [W-1:0]        r_a;
   logic [W-1:0]        r_b;
   logic [W-1:0]        r_sum;
   logic                r_cout;
   logic                r_in_ready;
   logic                r_out_valid;
   logic                r_busy;
   logic [BYTE_W-1:0]   r_add_a;
   logic [BYTE_W-1:0]   r_add_b;
   logic                r_add_cin;

   // r_a/r_b hold only the bytes not yet issued, so the next slice is always [7:0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_add_a     <= '0;
         r_add_b     <= '0;
         r_add_cin   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_a        <= in_a >> BYTE_W;
                  r_b        <= in_b >> BYTE_W;
                  r_add_a    <= in_a[BYTE_W-1:0];
                  r_add_b    <= in_b[BYTE_W-1:0];
                  r_add_cin  <= in_cin;
                  r_idx      <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ISSUE;
               end
            end
            ISSUE: begin
               r_cnt   <= CNT_W'(ADD_LAT - 1);
               r_state <= WAIT;
            end
            WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  r_sum  <= (r_sum >> BYTE_W) | (W'(add_sum) << (W - BYTE_W));
                  r_cout <= add_cout;
                  if (r_idx == IDX_W'(NBYTES - 1)) begin
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     // Next slice carries in the carry just captured.
                     r_idx     <= r_idx + IDX_W'(1);
                     r_add_a   <= r_a[BYTE_W-1:0];
                     r_add_b   <= r_b[BYTE_W-1:0];
                     r_add_cin <= add_cout;
                     r_a       <= r_a >> BYTE_W;
                     r_b       <= r_b >> BYTE_W;
                     r_state   <= ISSUE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_add_a     <= '0;
                  r_add_b     <= '0;
                  r_add_cin   <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign out_sum   = r_sum;
   assign out_cout  = r_cout;
   assign add_a     = r_add_a;
   assign add_b     = r_add_b;
   assign add_cin   = r_add_cin;

endmodule : wide_add_sequencer

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Upstream sequencer for the registered 8-bit adder stage. It accepts one wide operand pair (NBYTES bytes each) over a valid/ready handshake. It then feeds the adder one byte slice at a time, least-significant byte first, chaining each captured carry-out into the next slice's carry-in, and assembles the returned sum bytes into a wide result. The result and final carry are presented on a valid/ready output. The adder itself sits outside this block, with its active-high `rst` driven from `!rst_n` at the top level.

## Interface
- `NBYTES`, 4: operand width in bytes (≥1).
- `ADD_LAT`, 1: adder latency in cycles from operands driven to sum/cout valid (≥1).

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept operands.
- `in_a`  in  8*NBYTES  operand A.
- `in_b`  in  8*NBYTES  operand B.
- `in_cin`  in  1  carry-in to byte 0.
- `add_a`  out  8  byte slice of A to the adder.
- `add_b`  out  8  byte slice of B to the adder.
- `add_cin`  out  1  carry-in to the adder.
- `add_sum`  in  8  adder sum.
- `add_cout`  in  1  adder carry-out.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  8*NBYTES  wide sum, mod 2^(8*NBYTES).
- `out_cout`  out  1  carry out of the MSB.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `out_sum`=0, `out_cout`=0, `add_a`=0, `add_b`=0, `add_cin`=0. The state is IDLE, and the byte index and wait counter are 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid&&in_ready`, latch `in_a`, `in_b` and `in_cin`, set byte index 0, and go to ISSUE.
  - Adder outputs are driven to 0 in this state.
- ISSUE (exactly 1 cycle):
  - `add_a` = A byte[idx], `add_b` = B byte[idx].
  - `add_cin` = `in_cin` for idx 0, otherwise the captured carry from byte idx-1.
  - Load the wait counter with ADD_LAT-1, then go to WAIT.
- WAIT:
  - Adder outputs are held stable.
  - While the counter is nonzero, decrement it.
  - At counter 0, capture `add_sum` into result byte[idx] and `add_cout` into the carry register.
  - If idx == NBYTES-1, go to DONE; otherwise increment idx and go to ISSUE.
- DONE:
  - `out_valid`=1.
  - `out_sum` and `out_cout` are stable and equal to the captured values.
  - On `out_ready`, go to IDLE.
- No overlap: `in_ready`=0 outside IDLE. `in_valid` is ignored while busy.
- `out_sum` and `out_cout` retain their last values after leaving DONE, until the next capture overwrites them.
- Reset asserted mid-operation aborts immediately: all outputs take their reset values, and the partial result is discarded.

## Timing
- Taking the accepting edge as edge 0, byte i is captured at edge (i+1)*(1+ADD_LAT).
- `out_valid` rises after edge NBYTES*(1+ADD_LAT): edge 8 with the defaults.
- `out_ready` may already be high when `out_valid` rises. The handshake then completes at the next edge, and `in_ready` is high in the following cycle.
- Minimum issue interval between operand pairs is NBYTES*(1+ADD_LAT)+2 cycles.
- `add_*` outputs are registered and change only on ISSUE entry or on return to IDLE.

## Structure
- Shared package `wadd_pkg`:
  - `BYTE_W` = 8.
  - State enum `wadd_state_t` {IDLE, ISSUE, WAIT, DONE}.
- Operand A and B are held in right-shift registers so the byte slice is always bits [7:0]. Result bytes are shifted in from the top.
- No sub-module is required. The adder is instantiated beside this block at the top level.

## Test plan
- A=0x000000FF, B=0x00000001, cin=0 -> `out_sum`=0x00000100, `out_cout`=0, `out_valid` high after edge 8; the carry is observed on `add_cin`=1 during byte 1 ISSUE.
- A=0xFFFFFFFF, B=0x00000000, cin=1 -> `out_sum`=0x00000000, `out_cout`=1.
- A=0x12345678, B=0x11111111 with `out_ready` held low 5 cycles after `out_valid` -> 0x23456789 held stable all 5 cycles; `in_ready`=0 throughout; back in IDLE one edge after `out_ready`.
- Second `in_valid` (A=1, B=1) asserted while busy -> not accepted. After the first result is taken, it is accepted, yielding 0x00000002.
- `rst_n` pulsed low during byte 2 WAIT -> all outputs at reset values, asynchronously; `in_ready`=1 after release; a fresh operation gives the correct sum.
- ADD_LAT=2, NBYTES=2, A=0x80FF, B=0x8001 -> `out_sum`=0x0100, `out_cout`=1, `out_valid` high after edge 6.
